cmp_alarm_fsm: RTL and testbench
================================

# cmp_alarm_fsm

Sequential event tracker that sits directly downstream of the 8-bit magnitude comparator and consumes its per-sample equal/greater/less flags. It counts sample outcomes and runs a debounced alarm state machine: the alarm raises after HOLD consecutive "greater" samples and releases after HOLD consecutive "less" samples. Malformed flag sets are detected and latched as a sticky error.

## Interface
- HOLD, default 4: consecutive qualifying samples needed to raise or release the alarm; legal range 1..255.
- CNT_W, default 8: width of each outcome counter.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of counters, error and FSM.
- in_valid  input  1  flags on com/great/less are a valid sample this cycle.
- com  input  1  comparator equal flag.
- great  input  1  comparator greater flag.
- less  input  1  comparator less flag.
- alarm  output  1  high in ALARM and RELEASE states.
- state  output  2  FSM state: 0 IDLE, 1 ARMING, 2 ALARM, 3 RELEASE.
- eq_count  output  CNT_W  valid samples with com.
- gt_count  output  CNT_W  valid samples with great.
- lt_count  output  CNT_W  valid samples with less.
- err  output  1  sticky: a valid sample had flags that were not exactly one-hot.

## Operation
- A sample is legal when in_valid=1 and exactly one of {com, great, less} is 1.
- An illegal valid sample sets err, updates no counter, and leaves state and run unchanged.
- in_valid=0: no change to any register.
- Counters: a legal sample increments the matching counter by 1. Each counter saturates at 2^CNT_W-1 and does not wrap.
- The internal run counter is ceil(log2(HOLD+1)) bits wide and counts consecutive qualifying legal samples.
- FSM transitions, evaluated on legal samples only:
  - IDLE: great sets run=1 and moves to ARMING. If HOLD=1, great moves directly to ALARM with run=0. com or less: stay in IDLE.
  - ARMING: great increments run. When run+1=HOLD, move to ALARM and set run=0. com or less: move to IDLE and set run=0.
  - ALARM: great or com: stay. less sets run=1 and moves to RELEASE. If HOLD=1, less moves directly to IDLE with run=0.
  - RELEASE: less increments run. When run+1=HOLD, move to IDLE and set run=0. great: move to ALARM and set run=0. com: set run=0 and stay in RELEASE.
- alarm = (state==ALARM) or (state==RELEASE). It is decoded from the registered state, with no combinational path from the inputs.
- clr=1 has the following effect:
  - All counters, err and run go to 0, and state goes to IDLE.
  - clr takes priority over a sample in the same cycle; that sample is discarded.
- rst has the same effect as clr, applied asynchronously. rst may assert at any point mid-sequence; there is no partial retention.

## Timing
- Reset values: alarm=0, state=0, eq_count=gt_count=lt_count=0, err=0.
- All outputs are registered. A sample presented at edge N is reflected in the outputs after edge N (1-cycle latency).
- The block accepts one sample per cycle and applies no backpressure. Back-to-back valid cycles are fully supported.
- An alarm raise needs HOLD consecutive legal great samples. Invalid cycles (in_valid=0) and illegal samples in between do not break the run.
- Latency from the HOLD-th great sample to alarm=1 is one clock edge.
- rst deassertion is synchronised externally. The first sample is accepted on the first edge with rst low.

## Test plan
- Raise, HOLD=4: reset, then 4 consecutive great samples. Required: state goes 1,1,1,2; alarm=1 after the 4th edge; gt_count=4.
- Broken run, HOLD=4: great, great, com, great. Required: state=1 after the last sample (run restarted), alarm=0, eq_count=1, gt_count=3.
- Release with com hold: from ALARM, apply less, com, less×4. Required: state=3 through the com (run reset); after the 4 consecutive less samples, state=0 and alarm=0; lt_count=5.
- Illegal flags: valid sample with great=less=1, then a sample with all flags 0. Required: err=1 and stays 1, all counters unchanged, state unchanged. A later clr pulse returns err to 0.
- Saturation, CNT_W=3: 9 valid com samples. Required: eq_count=7 after the 7th sample and still 7 after the 9th.
- Clear/reset priority: clr with a valid great in the same cycle → all counts 0, state=0. Asserting rst asynchronously mid-ARMING (between clock edges) → outputs at reset values immediately; after release, 4 great samples are needed to raise the alarm.

Source files
------------

// File: rtl/cmp_alarm_fsm.sv
// Event tracker downstream of the 8-bit magnitude comparator: saturating outcome counters,
// a debounced alarm FSM (raise on HOLD greats, release on HOLD lesses) and a sticky flag error.
`timescale 1ns/1ps

module cmp_alarm_fsm #(
    parameter int unsigned HOLD  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             com,
    input  logic             great,
    input  logic             less,
    output logic             alarm,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic             err
);

    localparam int unsigned RUN_W = $clog2(HOLD + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMING  = 2'd1;
    localparam logic [1:0] ALARM   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    // Run value seen on the sample that completes a qualifying streak.
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HOLD - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               HOLD_ONE = (HOLD == 1);

    logic [1:0]       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] eq_q, eq_d;
    logic [CNT_W-1:0] gt_q, gt_d;
    logic [CNT_W-1:0] lt_q, lt_d;
    logic             err_q, err_d;

    logic one_hot;
    logic legal;
    logic illegal;

    // Odd parity without all three set means exactly one flag is high.
    assign one_hot = (com ^ great ^ less) & ~(com & great & less);
    assign legal   = in_valid & one_hot;
    assign illegal = in_valid & ~one_hot;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (legal) begin
            case (state_q)
                IDLE: begin
                    if (great) begin
                        if (HOLD_ONE) begin
                            state_d = ALARM;
                            run_d   = '0;
                        end else begin
                            state_d = ARMING;
                            run_d   = RUN_ONE;
                        end
                    end
                end
                ARMING: begin
                    if (great) begin
                        if (run_q == RUN_LAST) begin
                            state_d = ALARM;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_ONE;
                        end
                    end else begin
                        state_d = IDLE;
                        run_d   = '0;
                    end
                end
                ALARM: begin
                    if (less) begin
                        if (HOLD_ONE) begin
                            state_d = IDLE;
                            run_d   = '0;
                        end else begin
                            state_d = RELEASE;
                            run_d   = RUN_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (less) begin
                        if (run_q == RUN_LAST) begin
                            state_d = IDLE;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_ONE;
                        end
                    end else if (great) begin
                        state_d = ALARM;
                        run_d   = '0;
                    end else begin
                        // An equal sample restarts the release streak but keeps the alarm up.
                        run_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        eq_d  = eq_q;
        gt_d  = gt_q;
        lt_d  = lt_q;
        err_d = err_q | illegal;
        if (legal && com && (eq_q != CNT_MAX)) begin
            eq_d = eq_q + CNT_ONE;
        end
        if (legal && great && (gt_q != CNT_MAX)) begin
            gt_d = gt_q + CNT_ONE;
        end
        if (legal && less && (lt_q != CNT_MAX)) begin
            lt_d = lt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            eq_q    <= '0;
            gt_q    <= '0;
            lt_q    <= '0;
            err_q   <= 1'b0;
        end else if (clr) begin
            state_q <= IDLE;
            run_q   <= '0;
            eq_q    <= '0;
            gt_q    <= '0;
            lt_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
        end
    end

    assign state    = state_q;
    assign alarm    = state_q[1];
    assign eq_count = eq_q;
    assign gt_count = gt_q;
    assign lt_count = lt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cmp_alarm_fsm.sv
// Bench for cmp_alarm_fsm: three instances (HOLD=4/CNT_W=8, HOLD=4/CNT_W=3, HOLD=1/CNT_W=8)
// share one stimulus stream and are compared against a streak-based reference model.
`timescale 1ns/1ps

module tb_cmp_alarm_fsm;

    logic clk;
    logic rst;
    logic clr;
    logic in_valid;
    logic com;
    logic great;
    logic less;

    logic       al0, al1, al2;
    logic [1:0] st0, st1, st2;
    logic       er0, er1, er2;
    logic [7:0] eq0, gt0, lt0;
    logic [2:0] eq1, gt1, lt1;
    logic [7:0] eq2, gt2, lt2;

    cmp_alarm_fsm #(.HOLD(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .com(com), .great(great),
        .less(less), .alarm(al0), .state(st0), .eq_count(eq0), .gt_count(gt0),
        .lt_count(lt0), .err(er0)
    );

    cmp_alarm_fsm #(.HOLD(4), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .com(com), .great(great),
        .less(less), .alarm(al1), .state(st1), .eq_count(eq1), .gt_count(gt1),
        .lt_count(lt1), .err(er1)
    );

    cmp_alarm_fsm #(.HOLD(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .com(com), .great(great),
        .less(less), .alarm(al2), .state(st2), .eq_count(eq2), .gt_count(gt2),
        .lt_count(lt2), .err(er2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: an alarm flag, a "releasing" flag and a streak length per instance.
    int hold_of[3] = '{4, 4, 1};
    int cmax[3]    = '{255, 7, 255};
    bit m_al[3];
    bit m_rel[3];
    bit m_err[3];
    int m_run[3];
    int m_eq[3];
    int m_gt[3];
    int m_lt[3];

    typedef struct {
        bit c_clr;
        bit v;
        bit c;
        bit g;
        bit l;
        int st;
        int al;
        int eq;
        int gt;
        int lt;
        int er;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_al[i]  = 1'b0;
            m_rel[i] = 1'b0;
            m_err[i] = 1'b0;
            m_run[i] = 0;
            m_eq[i]  = 0;
            m_gt[i]  = 0;
            m_lt[i]  = 0;
        end
    endfunction

    function automatic void model_step(input bit c_clr, input bit v, input bit c, input bit g,
                                       input bit l);
        if (c_clr) begin
            model_reset();
            return;
        end
        if (!v) return;
        for (int i = 0; i < 3; i++) begin
            if (int'(c) + int'(g) + int'(l) != 1) begin
                m_err[i] = 1'b1;
                continue;
            end
            if (c && m_eq[i] < cmax[i]) m_eq[i]++;
            if (g && m_gt[i] < cmax[i]) m_gt[i]++;
            if (l && m_lt[i] < cmax[i]) m_lt[i]++;
            if (!m_al[i]) begin
                if (g) begin
                    m_run[i]++;
                    if (m_run[i] == hold_of[i]) begin
                        m_al[i]  = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else begin
                if (l) begin
                    m_rel[i] = 1'b1;
                    m_run[i]++;
                    if (m_run[i] == hold_of[i]) begin
                        m_al[i]  = 1'b0;
                        m_rel[i] = 1'b0;
                        m_run[i] = 0;
                    end
                end else if (g) begin
                    m_rel[i] = 1'b0;
                    m_run[i] = 0;
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endfunction

    function automatic int model_state(input int i);
        if (!m_al[i]) return (m_run[i] > 0) ? 1 : 0;
        return m_rel[i] ? 3 : 2;
    endfunction

    task automatic check_all(input string tag);
        int a_st, a_al, a_eq, a_gt, a_lt, a_er;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    a_st = int'(st0); a_al = int'(al0); a_er = int'(er0);
                    a_eq = int'(eq0); a_gt = int'(gt0); a_lt = int'(lt0);
                end
                1: begin
                    a_st = int'(st1); a_al = int'(al1); a_er = int'(er1);
                    a_eq = int'(eq1); a_gt = int'(gt1); a_lt = int'(lt1);
                end
                default: begin
                    a_st = int'(st2); a_al = int'(al2); a_er = int'(er2);
                    a_eq = int'(eq2); a_gt = int'(gt2); a_lt = int'(lt2);
                end
            endcase
            chk($sformatf("%s dut%0d state", tag, i), a_st, model_state(i));
            chk($sformatf("%s dut%0d alarm", tag, i), a_al, int'(m_al[i]));
            chk($sformatf("%s dut%0d eq", tag, i), a_eq, m_eq[i]);
            chk($sformatf("%s dut%0d gt", tag, i), a_gt, m_gt[i]);
            chk($sformatf("%s dut%0d lt", tag, i), a_lt, m_lt[i]);
            chk($sformatf("%s dut%0d err", tag, i), a_er, int'(m_err[i]));
        end
    endtask

    task automatic apply(input bit c_clr, input bit v, input bit c, input bit g, input bit l);
        clr      = c_clr;
        in_valid = v;
        com      = c;
        great    = g;
        less     = l;
        @(posedge clk);
        #1;
        model_step(c_clr, v, c, g, l);
    endtask

    task automatic add(input bit c_clr, input bit v, input bit c, input bit g, input bit l,
                       input int st, input int al, input int eq, input int gt, input int lt,
                       input int er);
        vec_t r;
        r.c_clr = c_clr; r.v = v; r.c = c; r.g = g; r.l = l;
        r.st = st; r.al = al; r.eq = eq; r.gt = gt; r.lt = lt; r.er = er;
        tab.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mode;
        int r;
        bit v, c, g, l, k;

        // Expected values for the HOLD=4, CNT_W=8 instance.
        //   clr v c g l   st al eq gt lt er
        add(0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0);   // raise
        add(0, 1, 0, 1, 0, 1, 0, 0, 2, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0, 0, 3, 0, 0);
        add(0, 1, 0, 1, 0, 2, 1, 0, 4, 0, 0);
        add(0, 1, 0, 0, 1, 3, 1, 0, 4, 1, 0);   // release, com restarts the streak
        add(0, 1, 1, 0, 0, 3, 1, 1, 4, 1, 0);
        add(0, 1, 0, 0, 1, 3, 1, 1, 4, 2, 0);
        add(0, 1, 0, 0, 1, 3, 1, 1, 4, 3, 0);
        add(0, 1, 0, 0, 1, 3, 1, 1, 4, 4, 0);
        add(0, 1, 0, 0, 1, 0, 0, 1, 4, 5, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 4, 5, 0);   // invalid cycle
        add(0, 1, 0, 1, 1, 0, 0, 1, 4, 5, 1);   // illegal: great and less
        add(0, 1, 0, 0, 0, 0, 0, 1, 4, 5, 1);   // illegal: no flag
        add(0, 1, 0, 1, 0, 1, 0, 1, 5, 5, 1);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);   // clr beats the sample
        add(0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0);   // broken run
        add(0, 1, 0, 1, 0, 1, 0, 0, 2, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0, 1, 3, 0, 0);
        add(0, 1, 1, 1, 0, 1, 0, 1, 3, 0, 1);   // illegal mid-run keeps the streak
        add(0, 0, 0, 0, 1, 1, 0, 1, 3, 0, 1);
        add(0, 1, 0, 1, 0, 1, 0, 1, 4, 0, 1);
        add(0, 1, 0, 1, 0, 1, 0, 1, 5, 0, 1);
        add(0, 1, 0, 1, 0, 2, 1, 1, 6, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; com = 1'b0; great = 1'b0; less = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (tab[n]) begin
            apply(tab[n].c_clr, tab[n].v, tab[n].c, tab[n].g, tab[n].l);
            chk($sformatf("vec%0d state", n), int'(st0), tab[n].st);
            chk($sformatf("vec%0d alarm", n), int'(al0), tab[n].al);
            chk($sformatf("vec%0d eq", n), int'(eq0), tab[n].eq);
            chk($sformatf("vec%0d gt", n), int'(gt0), tab[n].gt);
            chk($sformatf("vec%0d lt", n), int'(lt0), tab[n].lt);
            chk($sformatf("vec%0d err", n), int'(er0), tab[n].er);
            check_all($sformatf("vec%0d", n));
        end

        // Saturation of the 3-bit counters.
        for (int n = 1; n <= 9; n++) begin
            apply(0, 1, 1, 0, 0);
            chk($sformatf("sat%0d eq3", n), int'(eq1), (n < 7) ? n : 7);
            chk($sformatf("sat%0d eq8", n), int'(eq0), n);
        end
        apply(1, 0, 0, 0, 0);

        // Asynchronous reset in the middle of ARMING.
        apply(0, 1, 0, 1, 0);
        apply(0, 1, 0, 1, 0);
        chk("arming before rst", int'(st0), 1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async rst state", int'(st0), 0);
        chk("async rst gt", int'(gt0), 0);
        check_all("async rst");
        #2;
        rst = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            apply(0, 1, 0, 1, 0);
            chk($sformatf("post rst g%0d state", n), int'(st0), (n < 4) ? 1 : 2);
            chk($sformatf("post rst g%0d alarm", n), int'(al0), (n < 4) ? 0 : 1);
        end
        check_all("post rst");

        // Randomised traffic with bursts favouring one outcome.
        mode = 0;
        for (int n = 0; n < 600; n++) begin
            if (n % 12 == 0) mode = $urandom_range(0, 2);
            k = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                {c, g, l} = 3'($urandom_range(0, 7));
            end else begin
                if (r >= 14) mode = $urandom_range(0, 2);
                c = (mode == 0);
                g = (mode == 1);
                l = (mode == 2);
            end
            apply(k, v, c, g, l);
            check_all($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
